// File: rtl/ycbcr_blob_tracker_pkg.sv
// Shared widths, tracker FSM encoding and default skin-tone window for the blob tracker.
// Holds no logic.
package ycbcr_blob_tracker_pkg;

  localparam int XW_DEF = 12;
  localparam int YW_DEF = 11;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } trk_state_t;

  localparam logic [7:0] SKIN_Y_MIN  = 8'd40;
  localparam logic [7:0] SKIN_CB_MIN = 8'd77;
  localparam logic [7:0] SKIN_CB_MAX = 8'd127;
  localparam logic [7:0] SKIN_CR_MIN = 8'd133;
  localparam logic [7:0] SKIN_CR_MAX = 8'd173;

endpackage

// File: rtl/ycbcr_blob_tracker_edge_detect.sv
// Registered-history edge detector; rise/fall are combinational on the current sample.
// Never stalls. Edges are suppressed until one real sample has been seen after reset.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic primed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= d;
      primed_q <= 1'b1;
    end
  end

  // Without primed_q, a level already high out of reset would look like a rise.
  assign rise = primed_q & d & ~prev_q;
  assign fall = primed_q & ~d & prev_q;

endmodule

// File: rtl/ycbcr_blob_tracker.sv
// YCbCr window classifier with per-frame hit count, coordinate sums and bounding box.
// Video/mask latency 1 cycle; results strobe 1 cycle after frame end. No backpressure.
module ycbcr_blob_tracker
  import ycbcr_blob_tracker_pkg::*;
#(
  parameter int XW  = XW_DEF,
  parameter int YW  = YW_DEF,
  parameter int CW  = XW + YW,
  parameter int SXW = XW + CW,
  parameter int SYW = YW + CW
) (
  input  logic           iClk,
  input  logic           iRst_n,
  input  logic [7:0]     iY,
  input  logic [7:0]     iCb,
  input  logic [7:0]     iCr,
  input  logic           iHSync,
  input  logic           iVSync,
  input  logic           iLineValid,
  input  logic           iFrameValid,
  input  logic [7:0]     iYMin,
  input  logic [7:0]     iCbMin,
  input  logic [7:0]     iCbMax,
  input  logic [7:0]     iCrMin,
  input  logic [7:0]     iCrMax,
  output logic [7:0]     oY,
  output logic [7:0]     oCb,
  output logic [7:0]     oCr,
  output logic           oHSync,
  output logic           oVSync,
  output logic           oLineValid,
  output logic           oFrameValid,
  output logic           oMask,
  output logic [CW-1:0]  oCount,
  output logic [SXW-1:0] oSumX,
  output logic [SYW-1:0] oSumY,
  output logic [XW-1:0]  oXMin,
  output logic [XW-1:0]  oXMax,
  output logic [YW-1:0]  oYMin,
  output logic [YW-1:0]  oYMax,
  output logic           oResultValid
);

  logic pv, hit;
  logic lv_rise_unused, lv_fall, fv_rise, fv_fall;

  assign pv  = iLineValid & iFrameValid;
  assign hit = pv & (iY >= iYMin)
                  & (iCb >= iCbMin) & (iCb <= iCbMax)
                  & (iCr >= iCrMin) & (iCr <= iCrMax);

  edge_detect u_lv_edge (
    .clk   (iClk),
    .rst_n (iRst_n),
    .d     (iLineValid),
    .rise  (lv_rise_unused),
    .fall  (lv_fall)
  );

  edge_detect u_fv_edge (
    .clk   (iClk),
    .rst_n (iRst_n),
    .d     (iFrameValid),
    .rise  (fv_rise),
    .fall  (fv_fall)
  );

  // Pixel coordinates of the current input sample.
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = '0;
    if (pv) x_d = (x_q == '1) ? x_q : x_q + 1'b1;
    y_d = '0;
    if (iFrameValid) y_d = (lv_fall && (y_q != '1)) ? y_q + 1'b1 : y_q;
  end

  trk_state_t state_q, state_d;
  logic acc_clr, acc_en, rpt_load;

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (fv_rise) begin
          state_d = ST_ACTIVE;
          acc_clr = 1'b1;
          acc_en  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        acc_en = 1'b1;
        if (fv_fall) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        // Only one idle cycle between frames: this cycle may already be the next rise.
        if (iFrameValid) begin
          state_d = ST_ACTIVE;
          acc_clr = 1'b1;
          acc_en  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign rpt_load = (state_q == ST_ACTIVE) & fv_fall;

  logic [CW-1:0]  cnt_q, cnt_b, cnt_d;
  logic [SXW-1:0] sum_x_q, sum_x_b, sum_x_d;
  logic [SYW-1:0] sum_y_q, sum_y_b, sum_y_d;
  logic [XW-1:0]  xmin_q, xmin_b, xmin_d, xmax_q, xmax_b, xmax_d;
  logic [YW-1:0]  ymin_q, ymin_b, ymin_d, ymax_q, ymax_b, ymax_d;

  always_comb begin
    cnt_b   = acc_clr ? '0 : cnt_q;
    sum_x_b = acc_clr ? '0 : sum_x_q;
    sum_y_b = acc_clr ? '0 : sum_y_q;
    xmin_b  = acc_clr ? '1 : xmin_q;
    xmax_b  = acc_clr ? '0 : xmax_q;
    ymin_b  = acc_clr ? '1 : ymin_q;
    ymax_b  = acc_clr ? '0 : ymax_q;
    cnt_d   = cnt_b;
    sum_x_d = sum_x_b;
    sum_y_d = sum_y_b;
    xmin_d  = xmin_b;
    xmax_d  = xmax_b;
    ymin_d  = ymin_b;
    ymax_d  = ymax_b;
    if (acc_en && hit) begin
      cnt_d   = (cnt_b == '1) ? cnt_b : cnt_b + 1'b1;
      sum_x_d = sum_x_b + SXW'(x_q);
      sum_y_d = sum_y_b + SYW'(y_q);
      if (x_q < xmin_b) xmin_d = x_q;
      if (x_q > xmax_b) xmax_d = x_q;
      if (y_q < ymin_b) ymin_d = y_q;
      if (y_q > ymax_b) ymax_d = y_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oY          <= '0;
      oCb         <= '0;
      oCr         <= '0;
      oHSync      <= 1'b0;
      oVSync      <= 1'b0;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
      oMask       <= 1'b0;
    end else begin
      oY          <= iY;
      oCb         <= iCb;
      oCr         <= iCr;
      oHSync      <= iHSync;
      oVSync      <= iVSync;
      oLineValid  <= iLineValid;
      oFrameValid <= iFrameValid;
      oMask       <= hit;
    end
  end

  // pv is low on the frame-fall cycle, so the accumulators are already final here.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oCount       <= '0;
      oSumX        <= '0;
      oSumY        <= '0;
      oXMin        <= '0;
      oXMax        <= '0;
      oYMin        <= '0;
      oYMax        <= '0;
      oResultValid <= 1'b0;
    end else begin
      oResultValid <= rpt_load;
      if (rpt_load) begin
        oCount <= cnt_q;
        oSumX  <= sum_x_q;
        oSumY  <= sum_y_q;
        if (cnt_q == '0) begin
          oXMin <= '0;
          oXMax <= '0;
          oYMin <= '0;
          oYMax <= '0;
        end else begin
          oXMin <= xmin_q;
          oXMax <= xmax_q;
          oYMin <= ymin_q;
          oYMax <= ymax_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_blob_tracker.sv
// Directed bench for ycbcr_blob_tracker: reset, window edges and per-frame statistics.
module tb_ycbcr_blob_tracker;
  import ycbcr_blob_tracker_pkg::*;

  localparam int XW  = 12;
  localparam int YW  = 11;
  localparam int CW  = XW + YW;
  localparam int SXW = XW + CW;
  localparam int SYW = YW + CW;

  logic           iClk = 1'b0;
  logic           iRst_n = 1'b0;
  logic [7:0]     iY = '0, iCb = '0, iCr = '0;
  logic           iHSync = 1'b0, iVSync = 1'b0, iLineValid = 1'b0, iFrameValid = 1'b0;
  logic [7:0]     iYMin, iCbMin, iCbMax, iCrMin, iCrMax;
  logic [7:0]     oY, oCb, oCr;
  logic           oHSync, oVSync, oLineValid, oFrameValid, oMask;
  logic [CW-1:0]  oCount;
  logic [SXW-1:0] oSumX;
  logic [SYW-1:0] oSumY;
  logic [XW-1:0]  oXMin, oXMax;
  logic [YW-1:0]  oYMin, oYMax;
  logic           oResultValid;

  ycbcr_blob_tracker dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iY(iY), .iCb(iCb), .iCr(iCr),
    .iHSync(iHSync), .iVSync(iVSync), .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .iYMin(iYMin), .iCbMin(iCbMin), .iCbMax(iCbMax), .iCrMin(iCrMin), .iCrMax(iCrMax),
    .oY(oY), .oCb(oCb), .oCr(oCr),
    .oHSync(oHSync), .oVSync(oVSync), .oLineValid(oLineValid), .oFrameValid(oFrameValid),
    .oMask(oMask), .oCount(oCount), .oSumX(oSumX), .oSumY(oSumY),
    .oXMin(oXMin), .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax),
    .oResultValid(oResultValid)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] cnt, sx, sy, x0, x1, y0, y1;
    int          cyc;
  } res_t;

  res_t res_q[$];
  res_t mon_r;

  always @(negedge iClk) begin
    if (oResultValid) begin
      mon_r.cnt = 64'(oCount);
      mon_r.sx  = 64'(oSumX);
      mon_r.sy  = 64'(oSumY);
      mon_r.x0  = 64'(oXMin);
      mon_r.x1  = 64'(oXMax);
      mon_r.y0  = 64'(oYMin);
      mon_r.y1  = 64'(oYMax);
      mon_r.cyc = cyc;
      res_q.push_back(mon_r);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic fv, input logic [7:0] y,
                       input logic [7:0] cb, input logic [7:0] cr);
    iLineValid  = lv;
    iFrameValid = fv;
    iHSync      = ~lv;
    iVSync      = ~fv;
    iY  = y;
    iCb = cb;
    iCr = cr;
    @(posedge iClk);
    #1;
  endtask

  task automatic drive_px(input logic lv, input logic fv, input logic hit);
    if (hit) drive(lv, fv, 8'd100, 8'd100, 8'd150);
    else     drive(lv, fv, 8'd10,  8'd100, 8'd150);
  endtask

  // One frame: lead cycle, w x h pixels with one blank cycle between lines,
  // then the fall cycle. Pixels with linear index in [a, b) hit.
  task automatic run_frame(input int w, input int h, input int a, input int b,
                           output int fall_cyc);
    drive_px(1'b0, 1'b1, 1'b0);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++)
        drive_px(1'b1, 1'b1, ((r * w + c) >= a) && ((r * w + c) < b));
      if (r != h - 1) drive_px(1'b0, 1'b1, 1'b0);
    end
    fall_cyc = cyc;
    drive_px(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_result(input string tag, input int cnt, input int sx, input int sy,
                               input int x0, input int x1, input int y0, input int y1,
                               input int cyc_exp);
    res_t r;
    if (res_q.size() == 0) begin
      check_eq({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      r = res_q.pop_front();
      check_eq({tag, "_cnt"},  r.cnt, 64'(cnt));
      check_eq({tag, "_sumx"}, r.sx,  64'(sx));
      check_eq({tag, "_sumy"}, r.sy,  64'(sy));
      check_eq({tag, "_xmin"}, r.x0,  64'(x0));
      check_eq({tag, "_xmax"}, r.x1,  64'(x1));
      check_eq({tag, "_ymin"}, r.y0,  64'(y0));
      check_eq({tag, "_ymax"}, r.y1,  64'(y1));
      check_eq({tag, "_cyc"},  64'(r.cyc), 64'(cyc_exp));
    end
  endtask

  int fa, fb;

  initial begin
    iYMin  = SKIN_Y_MIN;
    iCbMin = SKIN_CB_MIN;
    iCbMax = SKIN_CB_MAX;
    iCrMin = SKIN_CR_MIN;
    iCrMax = SKIN_CR_MAX;

    // Reset held while a frame is already running with hitting pixels.
    for (int i = 0; i < 3; i++) drive_px(1'b1, 1'b1, 1'b1);
    check_eq("rst_oY", 64'(oY), 64'd0);
    check_eq("rst_mask", 64'(oMask), 64'd0);
    check_eq("rst_fv", 64'(oFrameValid), 64'd0);
    check_eq("rst_count", 64'(oCount), 64'd0);
    check_eq("rst_xmin", 64'(oXMin), 64'd0);
    check_eq("rst_valid", 64'(oResultValid), 64'd0);

    iRst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_px(1'b1, 1'b1, 1'b1);
    drive_px(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive_px(1'b1, 1'b1, 1'b1);
    drive_px(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_px(1'b0, 1'b0, 1'b0);
    check_eq("rst_partial_no_strobe", 64'(res_q.size()), 64'd0);

    // Full 4x3 hit frame after the discarded partial one.
    run_frame(4, 3, 0, 12, fa);
    drive_px(1'b0, 1'b0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b0);
    expect_result("full", 12, 18, 12, 0, 3, 0, 2, fa + 1);
    check_eq("full_single_strobe", 64'(res_q.size()), 64'd0);

    // Window edges inside one line.
    drive_px(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'd100, 8'd77, 8'd150);
    check_eq("win_cbmin_mask", 64'(oMask), 64'd1);
    check_eq("win_cbmin_oCb", 64'(oCb), 64'd77);
    check_eq("win_lv_delay", 64'(oLineValid), 64'd1);
    check_eq("win_hs_delay", 64'(oHSync), 64'd0);
    drive(1'b1, 1'b1, 8'd100, 8'd127, 8'd150);
    check_eq("win_cbmax_mask", 64'(oMask), 64'd1);
    drive(1'b1, 1'b1, 8'd100, 8'd128, 8'd150);
    check_eq("win_cbmax1_mask", 64'(oMask), 64'd0);
    drive(1'b1, 1'b1, 8'd100, 8'd100, 8'd132);
    check_eq("win_crmin1_mask", 64'(oMask), 64'd0);
    check_eq("win_crmin1_oCr", 64'(oCr), 64'd132);
    fa = cyc;
    drive_px(1'b0, 1'b0, 1'b0);
    check_eq("win_fv_delay", 64'(oFrameValid), 64'd0);
    check_eq("win_hs_idle", 64'(oHSync), 64'd1);
    check_eq("win_vs_idle", 64'(oVSync), 64'd1);
    drive_px(1'b0, 1'b0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b0);
    expect_result("win", 2, 1, 0, 0, 1, 0, 0, fa + 1);

    // Single hit at (5, 6) in an 8x8 frame.
    run_frame(8, 8, 53, 54, fa);
    drive_px(1'b0, 1'b0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b0);
    expect_result("single", 1, 5, 6, 5, 5, 6, 6, fa + 1);

    // Empty frame still reports, with a zeroed bounding box.
    run_frame(4, 3, 0, 0, fa);
    drive_px(1'b0, 1'b0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b0);
    expect_result("empty", 0, 0, 0, 0, 0, 0, 0, fa + 1);
    check_eq("empty_single_strobe", 64'(res_q.size()), 64'd0);

    // Back-to-back frames, one idle cycle apart: 3 hits then 5 hits.
    run_frame(4, 3, 0, 3, fa);
    run_frame(4, 3, 0, 5, fb);
    drive_px(1'b0, 1'b0, 1'b0);
    drive_px(1'b0, 1'b0, 1'b0);
    expect_result("b2b_a", 3, 3, 0, 0, 2, 0, 0, fa + 1);
    expect_result("b2b_b", 5, 6, 1, 0, 3, 0, 1, fb + 1);
    check_eq("b2b_strobes", 64'(res_q.size()), 64'd0);
    check_eq("hold_count", 64'(oCount), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
